// File: rtl/tube_chan_fifo.sv
// rtl/tube_chan_fifo.sv - parametrised Tube data channel FIFO with threshold, sticky flags and irq
module tube_chan_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 24,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              h_rst_b,
    input  logic              soft_clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    input  logic [CNT_W-1:0]  thresh,
    input  logic              irq_en,
    input  logic              flag_clr,
    output logic [CNT_W-1:0]  count,
    output logic              avail,
    output logic              not_full,
    output logic              empty,
    output logic              overrun,
    output logic              underrun,
    output logic              irq
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic              wa;
    logic              ra;
    logic [CNT_W-1:0]  eff_thresh;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign ra = rd_en && (count != '0);
    assign wa = wr_en && ((count < FULL_CNT) || ra);

    always_comb begin
        eff_thresh = thresh;
        if (thresh == '0)
            eff_thresh = CNT_W'(1);
        else if (thresh > FULL_CNT)
            eff_thresh = FULL_CNT;
    end

    assign rd_data  = mem[rp];
    assign avail    = (count >= eff_thresh);
    assign not_full = (count < FULL_CNT);
    assign empty    = (count == '0);
    assign irq      = irq_en && avail;

    always_ff @(posedge clk) begin
        if (wa && !soft_clr)
            mem[wp] <= wr_data;
    end

    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (soft_clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wa)
                wp <= (wp == LAST_PTR) ? '0 : wp + PTR_W'(1);
            if (ra)
                rp <= (rp == LAST_PTR) ? '0 : rp + PTR_W'(1);
            if (wa && !ra)
                count <= count + CNT_W'(1);
            else if (ra && !wa)
                count <= count - CNT_W'(1);
        end
    end

    // A set event in the same cycle as flag_clr keeps the flag set.
    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (soft_clr) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (wr_en && !wa)
                overrun <= 1'b1;
            else if (flag_clr)
                overrun <= 1'b0;
            if (rd_en && !ra)
                underrun <= 1'b1;
            else if (flag_clr)
                underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tube_chan_fifo.sv
// tb/tb_tube_chan_fifo.sv - scoreboard bench for tube_chan_fifo at DEPTH 24 and DEPTH 5
module tb_tube_chan_fifo;
    logic       clk = 1'b0;
    logic       h_rst_b = 1'b0;
    logic       soft_clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0, irq_en = 1'b0, flag_clr = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic [4:0] thresh = 5'd1;
    logic [4:0] count;
    logic       avail, not_full, empty, overrun, underrun, irq;

    logic       wr5 = 1'b0, rd5 = 1'b0;
    logic [7:0] wd5 = '0;
    logic [7:0] rdd5;
    logic [2:0] cnt5;
    logic       av5, nf5, em5, ov5, un5, irq5;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] q[$];
    logic [7:0] q5[$];
    bit         mov = 0, mun = 0;

    always #5 clk = ~clk;

    tube_chan_fifo #(.DATA_W(8), .DEPTH(24)) u_dut (
        .clk(clk), .h_rst_b(h_rst_b), .soft_clr(soft_clr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .thresh(thresh), .irq_en(irq_en), .flag_clr(flag_clr),
        .count(count), .avail(avail), .not_full(not_full), .empty(empty), .overrun(overrun),
        .underrun(underrun), .irq(irq)
    );

    tube_chan_fifo #(.DATA_W(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .h_rst_b(h_rst_b), .soft_clr(1'b0), .wr_en(wr5), .wr_data(wd5),
        .rd_en(rd5), .rd_data(rdd5), .thresh(3'd1), .irq_en(1'b0), .flag_clr(1'b0),
        .count(cnt5), .avail(av5), .not_full(nf5), .empty(em5), .overrun(ov5),
        .underrun(un5), .irq(irq5)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    task automatic check_state();
        int t;
        bit av;
        t = int'(thresh);
        if (t == 0) t = 1;
        if (t > 24) t = 24;
        av = (q.size() >= t);
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("not_full", 32'(not_full), 32'(q.size() < 24));
        check("overrun", 32'(overrun), 32'(mov));
        check("underrun", 32'(underrun), 32'(mun));
        check("avail", 32'(avail), 32'(av));
        check("irq", 32'(irq), 32'(av && irq_en));
    endtask

    task automatic cycle(input bit wr, input logic [7:0] d, input bit rd, input bit fc, input bit sc);
        bit ra, wa;
        wr_en = wr; wr_data = d; rd_en = rd; flag_clr = fc; soft_clr = sc;
        ra = rd && (q.size() > 0);
        wa = wr && ((q.size() < 24) || ra);
        if (ra && !sc) check("rd_data", 32'(rd_data), 32'(q[0]));
        @(posedge clk); #1;
        if (sc) begin
            q.delete(); mov = 0; mun = 0;
        end else begin
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(d);
            if (wr && !wa) mov = 1; else if (fc) mov = 0;
            if (rd && !ra) mun = 1; else if (fc) mun = 0;
        end
        wr_en = 0; rd_en = 0; flag_clr = 0; soft_clr = 0;
        check_state();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 h_rst_b = 1'b1;
        check_state();

        // reset arriving in the middle of a write burst
        cycle(1, 8'hAA, 0, 0, 0);
        cycle(1, 8'hBB, 0, 0, 0);
        wr_en = 1; wr_data = 8'hCC;
        #2 h_rst_b = 1'b0;
        #1 q.delete(); mov = 0; mun = 0;
        check_state();
        @(posedge clk); #1;
        wr_en = 0; h_rst_b = 1'b1;
        check_state();

        for (int i = 0; i < 24; i++) cycle(1, 8'(8'h11 + i), 0, 0, 0);
        check("full_count", 32'(count), 32'd24);
        cycle(1, 8'h99, 0, 0, 0);
        check("overrun_on_full", 32'(overrun), 32'd1);
        for (int i = 0; i < 24; i++) cycle(0, 8'h00, 1, 0, 0);

        // sticky-flag priority: set event beats flag_clr, then flag_clr alone clears
        for (int i = 0; i < 24; i++) cycle(1, 8'(8'h40 + i), 0, 0, 0);
        cycle(1, 8'hEE, 0, 1, 0);
        check("overrun_set_wins", 32'(overrun), 32'd1);
        cycle(0, 8'h00, 0, 1, 0);
        check("overrun_cleared", 32'(overrun), 32'd0);

        cycle(1, 8'h77, 1, 0, 0);
        check("full_rw_count", 32'(count), 32'd24);
        for (int i = 0; i < 24; i++) cycle(0, 8'h00, 1, 0, 0);

        cycle(1, 8'h33, 1, 0, 0);
        check("empty_rw_underrun", 32'(underrun), 32'd1);
        check("empty_rw_data", 32'(rd_data), 32'h33);
        cycle(0, 8'h00, 1, 1, 0);

        // two-byte mode threshold and interrupt
        thresh = 5'd2; irq_en = 1'b1;
        cycle(1, 8'hA5, 0, 0, 0);
        cycle(1, 8'h5A, 0, 0, 0);
        check("irq_two_byte", 32'(irq), 32'd1);
        cycle(0, 8'h00, 1, 0, 0);
        thresh = 5'd0; #1 check_state();
        thresh = 5'd31; #1 check_state();
        thresh = 5'd1;
        cycle(0, 8'h00, 1, 0, 0);
        irq_en = 1'b0;

        // soft clear with 7 entries queued and a competing write
        for (int i = 0; i < 7; i++) cycle(1, 8'(8'h60 + i), 0, 0, 0);
        cycle(1, 8'hFF, 0, 0, 1);
        cycle(1, 8'hC3, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);

        // pointer wrap on the 5-deep instance
        for (int i = 0; i < 12; i++) begin
            wr5 = 1; wd5 = 8'(i); q5.push_back(8'(i));
            @(posedge clk); #1 wr5 = 0;
            check("wrap_cnt_wr", 32'(cnt5), 32'd1);
            rd5 = 1;
            check("wrap_data", 32'(rdd5), 32'(q5.pop_front()));
            @(posedge clk); #1 rd5 = 0;
            check("wrap_cnt_rd", 32'(cnt5), 32'd0);
        end
        check("wrap_flags", 32'({ov5, un5}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
